// File: rtl/mem_fifo_ctl_if.sv
// Bus between the FIFO controller, its producers/consumers and the dual-port RAM.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_fifo_ctl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  clr, wr_en, din, rd_en, mem_rdata,
    output dout, dout_valid, full, empty, count, overflow, underflow,
           mem_we, mem_waddr, mem_wdata, mem_raddr
  );

  modport master (
    output clr, wr_en, din, rd_en, mem_rdata,
    input  dout, dout_valid, full, empty, count, overflow, underflow,
           mem_we, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/mem_fifo_ctl.sv
// Circular-buffer controller for a dual-port RAM with a registered read address.
// Owns pointers, occupancy, flags and the RAM address/write-enable pins.
module mem_fifo_ctl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_fifo_ctl_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  dv_q, dv_d;
  logic                  wa, ra;

  // Flags come from registered state only: no full/empty bypass.
  assign wa = bus.wr_en & ~full_q & ~bus.clr & reset_n;
  assign ra = bus.rd_en & ~empty_q & ~bus.clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.wr_en & full_q);
    unf_d    = unf_q | (bus.rd_en & empty_q);
    dv_d     = ra;
    if (wa) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ra) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wa, ra})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dv_d     = 1'b0;
    end
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dv_q     <= dv_d;
    end
  end

  // The RAM latches mem_raddr at the same edge that advances rd_ptr.
  assign bus.mem_we     = wa;
  assign bus.mem_waddr  = wr_ptr_q;
  assign bus.mem_wdata  = bus.din;
  assign bus.mem_raddr  = rd_ptr_q;
  assign bus.dout       = bus.mem_rdata;
  assign bus.dout_valid = dv_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule
